// File: rtl/br_decoder.sv
// LEGv8 BR (branch-to-register) decoder: splits the instruction into control fields and registers the packed control word.
// Optional macro BR_OPCODE_CHECK_EN: when defined, non-BR opcodes produce a PC-increment NOP word instead.
module br_decoder #(
  parameter logic [10:0] BR_OPCODE = 11'b11010110000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] i,
  output logic [93:0] CW
);

  logic [4:0]  DA;
  logic [4:0]  SA;
  logic [4:0]  SB;
  logic [4:0]  FS;
  logic [1:0]  PS;
  logic [1:0]  enable;
  logic        regWrite;
  logic        memWrite;
  logic        PC_sel;
  logic        B_sel;
  logic        status_load;
  logic [63:0] k;
  logic        state;
  logic        is_br;

  // Opcode match and the bits a BR ignores; kept only to make intent explicit.
  logic        unused_bits;
  assign unused_bits = ^{is_br, i[15:10]};

`ifdef BR_OPCODE_CHECK_EN
  assign is_br = (i[31:21] == BR_OPCODE);
`else
  assign is_br = 1'b1;
`endif

  always_comb begin
    DA          = 5'd0;
    SA          = 5'd0;
    SB          = 5'd0;
    FS          = 5'd0;
    PS          = 2'b01;
    enable      = 2'b00;
    regWrite    = 1'b0;
    memWrite    = 1'b0;
    PC_sel      = 1'b0;
    B_sel       = 1'b0;
    status_load = 1'b0;
    k           = 64'd0;
    state       = 1'b0;
    if (is_br) begin
      // PC is loaded from bus A, which carries Rn.
      DA     = i[4:0];
      SA     = i[9:5];
      SB     = i[20:16];
      PS     = 2'b11;
      PC_sel = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      CW <= '0;
    end else begin
      CW <= {DA, SA, SB, FS, PS, enable, regWrite, memWrite,
             PC_sel, B_sel, status_load, k, state};
    end
  end

endmodule

// File: tb/tb_br_decoder.sv
// Scoreboard bench for br_decoder: expected control words are queued at drive time and compared one edge later.
module tb_br_decoder;

  logic        clock;
  logic        reset;
  logic [31:0] i;
  logic [93:0] CW;

  int vecs = 0;
  int errs = 0;
  logic [93:0] sb[$];
  logic [93:0] last_exp;

  br_decoder dut (
    .clock(clock),
    .reset(reset),
    .i    (i),
    .CW   (CW)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [93:0] got, input logic [93:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [93:0] model(input logic r, input logic [31:0] ins);
    logic [93:0] e;
    logic        br;
    e = '0;
`ifdef BR_OPCODE_CHECK_EN
    br = (ins[31:21] == 11'b11010110000);
`else
    br = 1'b1;
`endif
    if (!r) begin
      if (br) begin
        e[93:89] = ins[4:0];
        e[88:84] = ins[9:5];
        e[83:79] = ins[20:16];
        e[73:72] = 2'b11;
        e[67]    = 1'b1;
      end else begin
        e[73:72] = 2'b01;
      end
    end
    return e;
  endfunction

  task automatic apply(input logic r, input logic [31:0] ins, input string tag);
    logic [93:0] exp;
    @(negedge clock);
    reset = r;
    i     = ins;
    sb.push_back(model(r, ins));
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, CW, 94'd0);
    end else begin
      exp = sb.pop_front();
      chk(tag, CW, exp);
      last_exp = exp;
    end
  endtask

  initial begin
    reset = 1'b1;
    i     = 32'h0;

    apply(1'b1, 32'hD61F0020, "reset_edge1");
    apply(1'b1, 32'hD61F0020, "reset_edge2");

    apply(1'b0, 32'hD61F0020, "br_rn1");
    chk("br_rn1_da", {89'd0, CW[93:89]}, 94'd0);
    chk("br_rn1_sa", {89'd0, CW[88:84]}, 94'd1);
    chk("br_rn1_sb", {89'd0, CW[83:79]}, 94'd31);
    chk("br_rn1_ps", {92'd0, CW[73:72]}, 94'd3);
    chk("br_rn1_pcsel", {93'd0, CW[67]}, 94'd1);
    chk("br_rn1_k", {30'd0, CW[64:1]}, 94'd0);

    // Change i between edges: CW must not move until the next edge.
    #2 i = 32'hD61F03C0;
    #1 chk("hold_between_edges", CW, last_exp);

    apply(1'b0, 32'hD61F03C0, "br_rn30");
    chk("br_rn30_sa", {89'd0, CW[88:84]}, 94'd30);

    apply(1'b1, 32'hD61F0020, "reset_mid_stream");
    apply(1'b0, 32'h00000000, "zero_instr");
`ifdef BR_OPCODE_CHECK_EN
    chk("zero_instr_ps", {92'd0, CW[73:72]}, 94'd1);
`else
    chk("zero_instr_ps", {92'd0, CW[73:72]}, 94'd3);
    chk("zero_instr_pcsel", {93'd0, CW[67]}, 94'd1);
`endif

    for (int n = 0; n < 24; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      if (n[0]) ins[31:21] = 11'b11010110000;
      apply($urandom_range(0, 5) == 0, ins, "random");
    end

    apply(1'b0, 32'hD61F03E5, "br_final");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
